// File: rtl/dual_helix_pkg.sv
// Shared AXI-Lite request/response structs and response codes used across the dual_helix fabric.
package dual_helix_pkg;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
   } dhs_axil_ax_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } dhs_axil_w_t;

   typedef struct packed {
      logic [1:0] resp;
   } dhs_axil_b_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } dhs_axil_r_t;

   typedef struct packed {
      dhs_axil_ax_t aw;
      logic         aw_valid;
      dhs_axil_w_t  w;
      logic         w_valid;
      logic         b_ready;
      dhs_axil_ax_t ar;
      logic         ar_valid;
      logic         r_ready;
   } dhs_axil_req_t;

   typedef struct packed {
      logic         aw_ready;
      logic         w_ready;
      dhs_axil_b_t  b;
      logic         b_valid;
      logic         ar_ready;
      dhs_axil_r_t  r;
      logic         r_valid;
   } dhs_axil_resp_t;

endpackage

// File: rtl/simple_if_to_axil.sv
// Simple memory interface -> AXI-Lite initiator; independent write/read FSMs, one outstanding each, all outputs registered.
// AXI valid 1 cycle after request, completion pulse 1 cycle after B/R beat; mem_*ready_o low while busy (requester holds).
module simple_if_to_axil
   import dual_helix_pkg::*;
#(
   parameter type         req_t      = dhs_axil_req_t,
   parameter type         resp_t     = dhs_axil_resp_t,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    arst_ni,
   input  logic                    mem_we_i,
   input  logic [ADDR_WIDTH-1:0]   mem_waddr_i,
   input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i,
   output logic                    mem_wready_o,
   output logic                    mem_wvalid_o,
   output logic [1:0]              mem_wresp_o,
   input  logic                    mem_re_i,
   input  logic [ADDR_WIDTH-1:0]   mem_raddr_i,
   output logic                    mem_rready_o,
   output logic                    mem_rvalid_o,
   output logic [DATA_WIDTH-1:0]   mem_rdata_o,
   output logic [1:0]              mem_rresp_o,
   output req_t                    axil_req_o,
   input  resp_t                   axil_resp_i
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

   w_state_e                w_state_q, w_state_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic                    aw_valid_q, aw_valid_d;
   logic                    w_valid_q, w_valid_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic                    b_ready_q, b_ready_d;
   logic                    wready_q, wready_d;
   logic                    wvalid_q, wvalid_d;
   logic [1:0]              wresp_q, wresp_d;

   r_state_e                r_state_q, r_state_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic                    ar_valid_q, ar_valid_d;
   logic                    r_ready_q, r_ready_d;
   logic                    rready_q, rready_d;
   logic                    rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;

   always_comb begin
      w_state_d  = w_state_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      aw_valid_d = aw_valid_q;
      w_valid_d  = w_valid_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      b_ready_d  = b_ready_q;
      wready_d   = wready_q;
      wvalid_d   = 1'b0;
      wresp_d    = wresp_q;
      case (w_state_q)
         W_IDLE: begin
            if (mem_we_i) begin
               awaddr_d   = mem_waddr_i;
               wdata_d    = mem_wdata_i;
               wstrb_d    = mem_wstrb_i;
               aw_valid_d = 1'b1;
               w_valid_d  = 1'b1;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               wready_d   = 1'b0;
               w_state_d  = W_ADDR;
            end
         end
         W_ADDR: begin
            // AW and W retire independently, in either order
            if (aw_valid_q && axil_resp_i.aw_ready) begin
               aw_valid_d = 1'b0;
               aw_done_d  = 1'b1;
            end
            if (w_valid_q && axil_resp_i.w_ready) begin
               w_valid_d = 1'b0;
               w_done_d  = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               b_ready_d = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (axil_resp_i.b_valid) begin
               wresp_d   = axil_resp_i.b.resp;
               wvalid_d  = 1'b1;
               b_ready_d = 1'b0;
               wready_d  = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d  = r_state_q;
      araddr_d   = araddr_q;
      ar_valid_d = ar_valid_q;
      r_ready_d  = r_ready_q;
      rready_d   = rready_q;
      rvalid_d   = 1'b0;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (mem_re_i) begin
               araddr_d   = mem_raddr_i;
               ar_valid_d = 1'b1;
               rready_d   = 1'b0;
               r_state_d  = R_ADDR;
            end
         end
         R_ADDR: begin
            if (axil_resp_i.ar_ready) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               r_state_d  = R_DATA;
            end
         end
         R_DATA: begin
            if (axil_resp_i.r_valid) begin
               rdata_d   = axil_resp_i.r.data;
               rresp_d   = axil_resp_i.r.resp;
               rvalid_d  = 1'b1;
               r_ready_d = 1'b0;
               rready_d  = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         w_state_q  <= W_IDLE;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         b_ready_q  <= 1'b0;
         wready_q   <= 1'b1;
         wvalid_q   <= 1'b0;
         wresp_q    <= '0;
         r_state_q  <= R_IDLE;
         araddr_q   <= '0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         rready_q   <= 1'b1;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
      end else begin
         w_state_q  <= w_state_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         b_ready_q  <= b_ready_d;
         wready_q   <= wready_d;
         wvalid_q   <= wvalid_d;
         wresp_q    <= wresp_d;
         r_state_q  <= r_state_d;
         araddr_q   <= araddr_d;
         ar_valid_q <= ar_valid_d;
         r_ready_q  <= r_ready_d;
         rready_q   <= rready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   always_comb begin
      axil_req_o          = '0;
      axil_req_o.aw.addr  = awaddr_q;
      axil_req_o.aw.prot  = 3'b000;
      axil_req_o.aw_valid = aw_valid_q;
      axil_req_o.w.data   = wdata_q;
      axil_req_o.w.strb   = wstrb_q;
      axil_req_o.w_valid  = w_valid_q;
      axil_req_o.b_ready  = b_ready_q;
      axil_req_o.ar.addr  = araddr_q;
      axil_req_o.ar.prot  = 3'b000;
      axil_req_o.ar_valid = ar_valid_q;
      axil_req_o.r_ready  = r_ready_q;
   end

   assign mem_wready_o = wready_q;
   assign mem_wvalid_o = wvalid_q;
   assign mem_wresp_o  = wresp_q;
   assign mem_rready_o = rready_q;
   assign mem_rvalid_o = rvalid_q;
   assign mem_rdata_o  = rdata_q;
   assign mem_rresp_o  = rresp_q;

endmodule

// File: tb/tb_simple_if_to_axil.sv
// Bench for simple_if_to_axil: delay-programmable AXI-Lite responder, directed vector table and randomized ops vs a word-level model.
module tb_simple_if_to_axil;
   import dual_helix_pkg::*;

   logic           clk_i = 1'b0;
   logic           arst_ni;
   logic           mem_we_i, mem_re_i;
   logic [31:0]    mem_waddr_i, mem_wdata_i, mem_raddr_i;
   logic [3:0]     mem_wstrb_i;
   logic           mem_wready_o, mem_wvalid_o, mem_rready_o, mem_rvalid_o;
   logic [1:0]     mem_wresp_o, mem_rresp_o;
   logic [31:0]    mem_rdata_o;
   dhs_axil_req_t  axil_req_o;
   dhs_axil_resp_t axil_resp_i;

   always #5 clk_i = ~clk_i;

   simple_if_to_axil dut (
      .clk_i(clk_i), .arst_ni(arst_ni),
      .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
      .mem_wstrb_i(mem_wstrb_i), .mem_wready_o(mem_wready_o), .mem_wvalid_o(mem_wvalid_o),
      .mem_wresp_o(mem_wresp_o), .mem_re_i(mem_re_i), .mem_raddr_i(mem_raddr_i),
      .mem_rready_o(mem_rready_o), .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
      .mem_rresp_o(mem_rresp_o), .axil_req_o(axil_req_o), .axil_resp_i(axil_resp_i)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // responder configuration and observations
   int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
   bit          r_force;
   logic [31:0] r_force_data;
   logic [1:0]  r_force_resp;
   logic [31:0] rsp_mem [32];
   logic [31:0] mdl_mem [32];
   logic [31:0] cap_aw_addr, cap_w_data, cap_ar_addr;
   logic [3:0]  cap_w_strb;
   logic [2:0]  cap_aw_prot, cap_ar_prot;
   int          stab_err = 0;

   task automatic init_mems();
      for (int i = 0; i < 32; i++) begin
         rsp_mem[i] = 32'hA5A5_0000 | i;
         mdl_mem[i] = 32'hA5A5_0000 | i;
      end
   endtask

   // AXI-Lite slave: readies/valids change at negedge only, handshakes land on the following posedge
   initial begin
      bit          p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, ar_got;
      bit          prv_aw, prv_w, prv_ar;
      int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
      logic [31:0] prv_aw_addr, prv_w_data, prv_ar_addr;
      logic [3:0]  prv_w_strb;
      axil_resp_i = '0;
      {p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, ar_got, prv_aw, prv_w, prv_ar} = '0;
      {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
      {prv_aw_addr, prv_w_data, prv_ar_addr, prv_w_strb} = '0;
      forever begin
         @(negedge clk_i);
         if (!arst_ni) begin
            axil_resp_i = '0;
            {p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, ar_got, prv_aw, prv_w, prv_ar} = '0;
            {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
         end else begin
            if (prv_aw && !p_aw && (!axil_req_o.aw_valid || axil_req_o.aw.addr !== prv_aw_addr))
               stab_err++;
            if (prv_w && !p_w && (!axil_req_o.w_valid || axil_req_o.w.data !== prv_w_data ||
                                  axil_req_o.w.strb !== prv_w_strb))
               stab_err++;
            if (prv_ar && !p_ar && (!axil_req_o.ar_valid || axil_req_o.ar.addr !== prv_ar_addr))
               stab_err++;
            if (p_aw) aw_got = 1'b1;
            if (p_w)  w_got  = 1'b1;
            if (p_ar) ar_got = 1'b1;
            if (p_b) begin axil_resp_i.b_valid = 1'b0; aw_got = 1'b0; w_got = 1'b0; end
            if (p_r) begin axil_resp_i.r_valid = 1'b0; ar_got = 1'b0; end
            axil_resp_i.aw_ready = 1'b0;
            axil_resp_i.w_ready  = 1'b0;
            axil_resp_i.ar_ready = 1'b0;
            if (!aw_got && axil_req_o.aw_valid) begin
               if (aw_cnt >= aw_dly) begin
                  axil_resp_i.aw_ready = 1'b1; aw_cnt = 0;
                  cap_aw_addr = axil_req_o.aw.addr; cap_aw_prot = axil_req_o.aw.prot;
               end else aw_cnt++;
            end
            if (!w_got && axil_req_o.w_valid) begin
               if (w_cnt >= w_dly) begin
                  axil_resp_i.w_ready = 1'b1; w_cnt = 0;
                  cap_w_data = axil_req_o.w.data; cap_w_strb = axil_req_o.w.strb;
               end else w_cnt++;
            end
            if (aw_got && w_got && !axil_resp_i.b_valid) begin
               if (b_cnt >= b_dly) begin
                  axil_resp_i.b_valid = 1'b1; b_cnt = 0;
                  axil_resp_i.b.resp = cap_aw_addr[6] ? AXI_SLVERR : AXI_OKAY;
                  if (!cap_aw_addr[6])
                     rsp_mem[cap_aw_addr[6:2]] = merge(rsp_mem[cap_aw_addr[6:2]], cap_w_data, cap_w_strb);
               end else b_cnt++;
            end
            if (!ar_got && axil_req_o.ar_valid) begin
               if (ar_cnt >= ar_dly) begin
                  axil_resp_i.ar_ready = 1'b1; ar_cnt = 0;
                  cap_ar_addr = axil_req_o.ar.addr; cap_ar_prot = axil_req_o.ar.prot;
               end else ar_cnt++;
            end
            if (ar_got && !axil_resp_i.r_valid) begin
               if (r_cnt >= r_dly) begin
                  axil_resp_i.r_valid = 1'b1; r_cnt = 0;
                  axil_resp_i.r.data = r_force ? r_force_data : rsp_mem[cap_ar_addr[6:2]];
                  axil_resp_i.r.resp = r_force ? r_force_resp : (cap_ar_addr[6] ? AXI_SLVERR : AXI_OKAY);
               end else r_cnt++;
            end
            p_aw = axil_resp_i.aw_ready && axil_req_o.aw_valid;
            p_w  = axil_resp_i.w_ready && axil_req_o.w_valid;
            p_b  = axil_resp_i.b_valid && axil_req_o.b_ready;
            p_ar = axil_resp_i.ar_ready && axil_req_o.ar_valid;
            p_r  = axil_resp_i.r_valid && axil_req_o.r_ready;
            prv_aw = axil_req_o.aw_valid; prv_aw_addr = axil_req_o.aw.addr;
            prv_w  = axil_req_o.w_valid;  prv_w_data = axil_req_o.w.data; prv_w_strb = axil_req_o.w.strb;
            prv_ar = axil_req_o.ar_valid; prv_ar_addr = axil_req_o.ar.addr;
         end
      end
   end

   typedef struct {
      bit          do_w, do_r;
      logic [31:0] waddr, wdata;
      logic [3:0]  wstrb;
      logic [31:0] raddr;
      int          aw_d, w_d, b_d, ar_d, r_d;
      bit          force_r;
      logic [31:0] force_data;
      logic [1:0]  force_resp;
      int          exp_wcyc;
      logic [1:0]  exp_wresp;
      int          exp_rcyc;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vec_t        v;
      int          n_awv, n_wv, n_brdy, n_arv, n_rrdy, wp, rp, wcyc, rcyc;
      logic [1:0]  wresp, rresp;
      logic [31:0] rdata;
      logic        wrdy_at, rrdy_at;
      int          rise_cyc, p1_cyc, p2_cyc, npulse, t;
      logic [31:0] rise_addr;
      bit          prev_awv, holding, got_w, got_r;

      //              w  r  waddr         wdata         strb   raddr         awd wd bd ard rd frc fdata         fresp wcyc wresp rcyc rdata         rresp
      vecs[0] = '{1, 0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        2'd0, 3, 2'd0, 0, 32'h0,        2'd0};
      vecs[1] = '{1, 0, 32'h0000_1008, 32'hCAFE_F00D, 4'h5, 32'h0,        3, 0, 0, 0, 0, 0, 32'h0,        2'd0, 6, 2'd0, 0, 32'h0,        2'd0};
      vecs[2] = '{0, 1, 32'h0,        32'h0,        4'h0, 32'h0000_1004, 0, 0, 0, 0, 5, 1, 32'h1234_5678, 2'd2, 0, 2'd0, 8, 32'h1234_5678, 2'd2};
      vecs[3] = '{1, 1, 32'h0000_1040, 32'h55AA_55AA, 4'hF, 32'h0000_1000, 1, 2, 0, 0, 0, 0, 32'h0,        2'd0, 5, 2'd2, 3, 32'hDEAD_BEEF, 2'd0};
      vecs[4] = '{0, 1, 32'h0,        32'h0,        4'h0, 32'h0000_1008, 0, 0, 0, 2, 1, 0, 32'h0,        2'd0, 0, 2'd0, 6, 32'hA5FE_000D, 2'd0};
      vecs[5] = '{1, 0, 32'h0000_1010, 32'h1122_3344, 4'h8, 32'h0,        0, 0, 4, 0, 0, 0, 32'h0,        2'd0, 7, 2'd0, 0, 32'h0,        2'd0};

      arst_ni = 1'b0;
      mem_we_i = 1'b0; mem_re_i = 1'b0;
      mem_waddr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0; mem_raddr_i = '0;
      {aw_dly, w_dly, b_dly, ar_dly, r_dly} = '0;
      r_force = 1'b0; r_force_data = '0; r_force_resp = '0;
      init_mems();
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_wready", mem_wready_o, 1);
      chk("rst_rready", mem_rready_o, 1);
      chk("rst_wvalid", mem_wvalid_o, 0);
      chk("rst_rvalid", mem_rvalid_o, 0);
      chk("rst_wresp", mem_wresp_o, 0);
      chk("rst_rresp", mem_rresp_o, 0);
      chk("rst_rdata", mem_rdata_o, 0);
      chk("rst_req_zero", axil_req_o == '0, 1);
      @(negedge clk_i);
      arst_ni = 1'b1;
      repeat (2) @(negedge clk_i);

      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
         r_force = v.force_r; r_force_data = v.force_data; r_force_resp = v.force_resp;
         @(negedge clk_i);
         mem_we_i = v.do_w; mem_waddr_i = v.waddr; mem_wdata_i = v.wdata; mem_wstrb_i = v.wstrb;
         mem_re_i = v.do_r; mem_raddr_i = v.raddr;
         {n_awv, n_wv, n_brdy, n_arv, n_rrdy, wp, rp, wcyc, rcyc} = '0;
         wresp = '0; rresp = '0; rdata = '0; wrdy_at = 1'b0; rrdy_at = 1'b0;
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            if (c == 1) begin mem_we_i = 1'b0; mem_re_i = 1'b0; end
            if (axil_req_o.aw_valid) n_awv++;
            if (axil_req_o.w_valid)  n_wv++;
            if (axil_req_o.b_ready)  n_brdy++;
            if (axil_req_o.ar_valid) n_arv++;
            if (axil_req_o.r_ready)  n_rrdy++;
            if (mem_wvalid_o) begin
               wp++;
               if (wp == 1) begin wcyc = c; wresp = mem_wresp_o; wrdy_at = mem_wready_o; end
            end
            if (mem_rvalid_o) begin
               rp++;
               if (rp == 1) begin rcyc = c; rdata = mem_rdata_o; rresp = mem_rresp_o; rrdy_at = mem_rready_o; end
            end
         end
         chk($sformatf("v%0d_wpulses", i), wp, v.do_w ? 1 : 0);
         chk($sformatf("v%0d_rpulses", i), rp, v.do_r ? 1 : 0);
         if (v.do_w) begin
            chk($sformatf("v%0d_wcyc", i), wcyc, v.exp_wcyc);
            chk($sformatf("v%0d_wresp", i), wresp, v.exp_wresp);
            chk($sformatf("v%0d_wready_back", i), wrdy_at, 1);
            chk($sformatf("v%0d_awvalid_cycles", i), n_awv, 1 + v.aw_d);
            chk($sformatf("v%0d_wvalid_cycles", i), n_wv, 1 + v.w_d);
            chk($sformatf("v%0d_bready_cycles", i), n_brdy, 1 + v.b_d);
            chk($sformatf("v%0d_aw_addr", i), cap_aw_addr, v.waddr);
            chk($sformatf("v%0d_aw_prot", i), cap_aw_prot, 0);
            chk($sformatf("v%0d_w_data", i), cap_w_data, v.wdata);
            chk($sformatf("v%0d_w_strb", i), cap_w_strb, v.wstrb);
         end else begin
            chk($sformatf("v%0d_no_aw", i), n_awv, 0);
         end
         if (v.do_r) begin
            chk($sformatf("v%0d_rcyc", i), rcyc, v.exp_rcyc);
            chk($sformatf("v%0d_rdata", i), rdata, v.exp_rdata);
            chk($sformatf("v%0d_rresp", i), rresp, v.exp_rresp);
            chk($sformatf("v%0d_rready_back", i), rrdy_at, 1);
            chk($sformatf("v%0d_arvalid_cycles", i), n_arv, 1 + v.ar_d);
            chk($sformatf("v%0d_rready_cycles", i), n_rrdy, 1 + v.r_d);
            chk($sformatf("v%0d_ar_addr", i), cap_ar_addr, v.raddr);
            chk($sformatf("v%0d_ar_prot", i), cap_ar_prot, 0);
         end
      end
      r_force = 1'b0;

      // busy hold: second write presented during W_RESP must wait for wready
      aw_dly = 0; w_dly = 0; b_dly = 3;
      @(negedge clk_i);
      mem_we_i = 1'b1; mem_waddr_i = 32'h0000_1020; mem_wdata_i = 32'h0BAD_0001; mem_wstrb_i = 4'hF;
      rise_cyc = 0; rise_addr = '0; p1_cyc = 0; p2_cyc = 0; npulse = 0; prev_awv = 1'b0; holding = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk_i);
         if (holding && mem_wready_o) holding = 1'b0;
         else if (!holding && c != 3) mem_we_i = 1'b0;
         if (c == 3) begin
            chk("busy_wready_low", mem_wready_o, 0);
            mem_we_i = 1'b1; mem_waddr_i = 32'h0000_1024; mem_wdata_i = 32'h0BAD_0002;
            holding = 1'b1;
         end
         if (c == 5) chk("busy_payload_kept", axil_req_o.aw.addr, 32'h0000_1020);
         if (axil_req_o.aw_valid && !prev_awv && c > 1) begin rise_cyc = c; rise_addr = axil_req_o.aw.addr; end
         prev_awv = axil_req_o.aw_valid;
         if (mem_wvalid_o) begin
            npulse++;
            if (npulse == 1) p1_cyc = c;
            if (npulse == 2) p2_cyc = c;
         end
      end
      chk("busy_pulses", npulse, 2);
      chk("busy_p1_cyc", p1_cyc, 6);
      chk("busy_second_aw_cyc", rise_cyc, 7);
      chk("busy_second_aw_addr", rise_addr, 32'h0000_1024);
      chk("busy_p2_cyc", p2_cyc, 12);
      chk("busy_w_data", cap_w_data, 32'h0BAD_0002);

      // asynchronous reset while AW is still waiting for ready
      aw_dly = 5; w_dly = 0; b_dly = 0;
      @(negedge clk_i);
      mem_we_i = 1'b1; mem_waddr_i = 32'h0000_1030; mem_wdata_i = 32'h7777_0000; mem_wstrb_i = 4'hF;
      @(negedge clk_i);
      mem_we_i = 1'b0;
      @(negedge clk_i);
      chk("rstmid_awvalid_before", axil_req_o.aw_valid, 1);
      #2 arst_ni = 1'b0;
      #1;
      chk("rstmid_awvalid", axil_req_o.aw_valid, 0);
      chk("rstmid_wvalid", axil_req_o.w_valid, 0);
      chk("rstmid_wready", mem_wready_o, 1);
      chk("rstmid_req_zero", axil_req_o == '0, 1);
      repeat (2) @(negedge clk_i);
      arst_ni = 1'b1;
      npulse = 0; n_awv = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk_i);
         if (mem_wvalid_o) npulse++;
         if (axil_req_o.aw_valid) n_awv++;
      end
      chk("rstmid_no_pulse", npulse, 0);
      chk("rstmid_no_aw", n_awv, 0);

      // randomized ops against the word-level memory model
      init_mems();
      for (int k = 0; k < 40; k++) begin
         int          kind, widx, ridx;
         logic [31:0] wa, wd, ra, exp_rd;
         logic [3:0]  ws;
         logic [1:0]  exp_wr, exp_rr;
         kind = $urandom_range(0, 2);
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
         ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
         widx = $urandom_range(0, 31); ridx = $urandom_range(0, 31);
         if (kind == 2 && ridx == widx) ridx = (widx + 1) % 32;
         wa = 32'h0000_2000 + 32'(widx * 4); ra = 32'h0000_2000 + 32'(ridx * 4);
         wd = $urandom; ws = 4'($urandom_range(1, 15));
         exp_wr = (widx >= 16) ? AXI_SLVERR : AXI_OKAY;
         exp_rr = (ridx >= 16) ? AXI_SLVERR : AXI_OKAY;
         exp_rd = mdl_mem[ridx];
         if (kind != 1 && exp_wr == AXI_OKAY) mdl_mem[widx] = merge(mdl_mem[widx], wd, ws);
         @(negedge clk_i);
         mem_we_i = (kind != 1); mem_waddr_i = wa; mem_wdata_i = wd; mem_wstrb_i = ws;
         mem_re_i = (kind != 0); mem_raddr_i = ra;
         got_w = (kind == 1); got_r = (kind == 0); t = 0;
         while (!(got_w && got_r) && t < 60) begin
            @(negedge clk_i);
            t++;
            if (t == 1) begin mem_we_i = 1'b0; mem_re_i = 1'b0; end
            if (mem_wvalid_o && !got_w) begin got_w = 1'b1; wresp = mem_wresp_o; end
            if (mem_rvalid_o && !got_r) begin got_r = 1'b1; rdata = mem_rdata_o; rresp = mem_rresp_o; end
         end
         #1;
         if (kind != 1) begin
            chk($sformatf("rnd%0d_wdone", k), got_w, 1);
            chk($sformatf("rnd%0d_wresp", k), wresp, exp_wr);
            chk($sformatf("rnd%0d_aw_addr", k), cap_aw_addr, wa);
            chk($sformatf("rnd%0d_w_data", k), cap_w_data, wd);
            chk($sformatf("rnd%0d_w_strb", k), cap_w_strb, ws);
         end
         if (kind != 0) begin
            chk($sformatf("rnd%0d_rdone", k), got_r, 1);
            chk($sformatf("rnd%0d_rdata", k), rdata, exp_rd);
            chk($sformatf("rnd%0d_rresp", k), rresp, exp_rr);
            chk($sformatf("rnd%0d_ar_addr", k), cap_ar_addr, ra);
         end
      end

      repeat (2) @(negedge clk_i);
      chk("axi_stability", stab_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
